uart_rx_core_param: RTL and testbench

//  Parametrised UART receive core that replaces the separate FSM, edge/bit counter, sampler,

---
 rtl/uart_rx_core_param.sv | 222 ++++++++++++++++++++++
 tb/tb_uart_rx_core_param.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core_param.sv
// rtl/uart_rx_core_param.sv - parametrised oversampling UART receive core with handshake output
//
// Purpose:
//   Receives asynchronous serial frames (start, DATA_W data bits LSB first,
//   optional parity, one or two stop bits) from a line that is already
//   synchronised to clk. Each bit is oversampled Prescale times. The bit value
//   is a 2-of-3 majority vote around mid-bit. Completed good words are handed
//   to the consumer through a 1-deep valid/ready output register.
//
// Ports:
//   clk         in   1           system clock
//   rst         in   1           asynchronous reset, active low
//   RX_IN       in   1           serial line, idle high
//   Prescale    in   PRESCALE_W  clocks per bit (values below 4 act as 4)
//   PAR_EN      in   1           parity bit present
//   PAR_TYP     in   1           0 = even, 1 = odd parity
//   STP2        in   1           two stop bits
//   P_DATA      out  DATA_W      received word
//   data_valid  out  1           output register holds an undelivered word
//   data_ready  in   1           consumer accepts P_DATA when data_valid is high
//   par_err     out  1           one-cycle pulse, parity mismatch
//   stp_err     out  1           one-cycle pulse, a stop bit was sampled 0
//   overrun     out  1           one-cycle pulse, good word dropped (register full)
//   busy        out  1           receiver is not idle

module uart_rx_core_param #(
    parameter int DATA_W     = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STP2,
    output logic [DATA_W-1:0]     P_DATA,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  overrun,
    output logic                  busy
);

    localparam int BW = $clog2(DATA_W + 5);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_W);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // Reset asserts immediately but is released only after two clean clock edges.
    logic [1:0] rst_sync;
    logic       rst_n_int;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n_int = rst_sync[1];

    logic [2:0]            state;
    logic [PRESCALE_W-1:0] edge_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_W-1:0]     shift;
    logic [2:0]            smp;
    logic                  perr;
    logic                  serr;
    logic                  stop2;

    // Frame configuration, frozen for the whole frame once the start edge is seen.
    logic [PRESCALE_W-1:0] p_lat;
    logic                  par_en_l;
    logic                  par_typ_l;
    logic                  stp2_l;

    logic [PRESCALE_W-1:0] p_clamp;
    logic [PRESCALE_W-1:0] mid;
    logic [PRESCALE_W-1:0] s0_pt;
    logic [PRESCALE_W-1:0] s2_pt;
    logic [PRESCALE_W-1:0] last_pt;
    logic                  last_edge;
    logic                  s2_eff;
    logic                  maj;
    logic                  serr_n;
    logic                  good;

    assign p_clamp   = (Prescale < PRESCALE_W'(4)) ? PRESCALE_W'(4) : Prescale;
    assign mid       = p_lat >> 1;
    assign s0_pt     = mid - 1'b1;
    assign s2_pt     = mid + 1'b1;
    assign last_pt   = p_lat - 1'b1;
    assign last_edge = (edge_cnt == last_pt);

    // With P=4 the third sample point coincides with the consume point, so the
    // live line value stands in for the not-yet-registered third sample.
    assign s2_eff = (edge_cnt == s2_pt) ? RX_IN : smp[2];
    assign maj    = (smp[0] & smp[1]) | (smp[0] & s2_eff) | (smp[1] & s2_eff);

    assign serr_n = serr | ~maj;
    assign good   = ~perr & ~serr_n;
    assign busy   = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state      <= ST_IDLE;
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            smp        <= '0;
            perr       <= 1'b0;
            serr       <= 1'b0;
            stop2      <= 1'b0;
            p_lat      <= PRESCALE_W'(4);
            par_en_l   <= 1'b0;
            par_typ_l  <= 1'b0;
            stp2_l     <= 1'b0;
            P_DATA     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            par_err <= 1'b0;
            stp_err <= 1'b0;
            overrun <= 1'b0;

            // Consumer handshake; a good frame ending on this edge overrides it below.
            if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end

            if (state == ST_IDLE) begin
                edge_cnt <= '0;
                bit_cnt  <= '0;
                if (!RX_IN) begin
                    state     <= ST_START;
                    edge_cnt  <= PRESCALE_W'(1);
                    p_lat     <= p_clamp;
                    par_en_l  <= PAR_EN;
                    par_typ_l <= PAR_TYP;
                    stp2_l    <= STP2;
                    perr      <= 1'b0;
                    serr      <= 1'b0;
                    stop2     <= 1'b0;
                end
            end else begin
                if (last_edge) begin
                    edge_cnt <= '0;
                    bit_cnt  <= bit_cnt + 1'b1;
                end else begin
                    edge_cnt <= edge_cnt + 1'b1;
                end

                if (edge_cnt == s0_pt) begin
                    smp[0] <= RX_IN;
                end
                if (edge_cnt == mid) begin
                    smp[1] <= RX_IN;
                end
                if (edge_cnt == s2_pt) begin
                    smp[2] <= RX_IN;
                end

                if (last_edge) begin
                    case (state)
                        ST_START: begin
                            if (maj) begin
                                // Start bit did not hold low through mid-bit: a glitch.
                                state   <= ST_IDLE;
                                bit_cnt <= '0;
                            end else begin
                                state <= ST_DATA;
                            end
                        end
                        ST_DATA: begin
                            shift <= {maj, shift[DATA_W-1:1]};
                            if (bit_cnt == LAST_DATA) begin
                                state <= par_en_l ? ST_PARITY : ST_STOP;
                            end
                        end
                        ST_PARITY: begin
                            perr  <= maj ^ (^shift) ^ par_typ_l;
                            state <= ST_STOP;
                        end
                        ST_STOP: begin
                            if (stp2_l && !stop2) begin
                                stop2 <= 1'b1;
                                serr  <= serr_n;
                            end else begin
                                state    <= ST_IDLE;
                                edge_cnt <= '0;
                                bit_cnt  <= '0;
                                par_err  <= perr;
                                stp_err  <= serr_n;
                                if (good) begin
                                    if (data_valid && !data_ready) begin
                                        overrun <= 1'b1;
                                    end else begin
                                        P_DATA     <= shift;
                                        data_valid <= 1'b1;
                                    end
                                end
                            end
                        end
                        default: begin
                            state <= ST_IDLE;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_core_param.sv
// tb/tb_uart_rx_core_param.sv - directed self-checking bench for uart_rx_core_param

module tb_uart_rx_core_param;

    logic       clk;
    logic       rst;
    logic       RX_IN;
    logic [5:0] Prescale;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       STP2;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       data_ready;
    logic       par_err;
    logic       stp_err;
    logic       overrun;
    logic       busy;

    int errors = 0;
    int checks = 0;

    uart_rx_core_param #(.DATA_W(8), .PRESCALE_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .RX_IN      (RX_IN),
        .Prescale   (Prescale),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .STP2       (STP2),
        .P_DATA     (P_DATA),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .par_err    (par_err),
        .stp_err    (stp_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Frame bits, index 0 = start bit, then data LSB first, parity, stop(s).
    function automatic logic [15:0] mk(input logic [7:0] d, input logic pen, input logic pbit,
                                       input logic s1, input logic s2, input logic st2);
        logic [15:0] b;
        int k;
        b = '1;
        b[0] = 1'b0;
        b[8:1] = d;
        k = 9;
        if (pen) begin
            b[k] = pbit;
            k++;
        end
        b[k] = s1;
        if (st2) begin
            b[k+1] = s2;
        end
        return b;
    endfunction

    // Called just after an edge E; the start bit is seen at T0 = E+1.
    // Returns just after edge T0 + n*p - 2, one edge before frame end.
    task automatic drive_frame(input logic [15:0] bits, input int n, input int p, input int flip_at);
        for (int i = 0; i < n; i++) begin
            RX_IN = bits[i];
            if (i == flip_at) begin
                PAR_EN = ~PAR_EN;
            end
            repeat ((i == n - 1) ? p - 1 : p) @(posedge clk);
            #1;
        end
    endtask

    task automatic final_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        RX_IN = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        RX_IN = 1'b1;
        Prescale = 6'd8;
        PAR_EN = 1'b0;
        PAR_TYP = 1'b0;
        STP2 = 1'b0;
        data_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_p_data", P_DATA, 8'h00);
        check("rst_valid", data_valid, 0);
        check("rst_par_err", par_err, 0);
        check("rst_stp_err", stp_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        rst = 1'b1;
        idle_cycles(4);

        // T1: P=8, 8N1, 0xA5, delivered at T0+79
        drive_frame(mk(8'hA5, 0, 0, 1, 1, 0), 10, 8, -1);
        check("t1_pre_valid", data_valid, 0);
        check("t1_pre_busy", busy, 1);
        final_edge();
        RX_IN = 1'b1;
        check("t1_valid", data_valid, 1);
        check("t1_data", P_DATA, 8'hA5);
        check("t1_par_err", par_err, 0);
        check("t1_stp_err", stp_err, 0);
        check("t1_busy", busy, 0);
        data_ready = 1'b1;
        final_edge();
        check("t1_accept", data_valid, 0);
        data_ready = 1'b0;
        idle_cycles(3);

        // T2: P=16, even parity, 0x3C with parity bit 1, par_err at T0+175
        Prescale = 6'd16;
        PAR_EN = 1'b1;
        PAR_TYP = 1'b0;
        drive_frame(mk(8'h3C, 1, 1, 1, 1, 0), 11, 16, -1);
        check("t2_pre_par_err", par_err, 0);
        final_edge();
        RX_IN = 1'b1;
        check("t2_par_err", par_err, 1);
        check("t2_stp_err", stp_err, 0);
        check("t2_valid", data_valid, 0);
        final_edge();
        check("t2_par_err_pulse", par_err, 0);
        PAR_EN = 1'b0;
        idle_cycles(3);

        // T3a: P=8, two stop bits, second stop bit 0
        Prescale = 6'd8;
        STP2 = 1'b1;
        drive_frame(mk(8'h81, 0, 0, 1, 0, 1), 11, 8, -1);
        final_edge();
        RX_IN = 1'b1;
        check("t3a_stp_err", stp_err, 1);
        check("t3a_valid", data_valid, 0);
        idle_cycles(3);

        // T3b: both stop bits good, delivered at T0+87
        drive_frame(mk(8'h81, 0, 0, 1, 1, 1), 11, 8, -1);
        check("t3b_pre_valid", data_valid, 0);
        final_edge();
        RX_IN = 1'b1;
        check("t3b_valid", data_valid, 1);
        check("t3b_data", P_DATA, 8'h81);
        check("t3b_stp_err", stp_err, 0);
        data_ready = 1'b1;
        final_edge();
        data_ready = 1'b0;
        STP2 = 1'b0;
        idle_cycles(3);

        // T4: two-cycle glitch, back to IDLE at T0+7
        RX_IN = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        RX_IN = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("t4_busy_t6", busy, 1);
        final_edge();
        check("t4_busy_t7", busy, 0);
        check("t4_valid", data_valid, 0);
        check("t4_par_err", par_err, 0);
        check("t4_stp_err", stp_err, 0);
        check("t4_data", P_DATA, 8'h81);
        idle_cycles(3);

        // Prescale below 4 is clamped to 4: 10 bits of 4 clocks, delivered at T0+39
        Prescale = 6'd2;
        drive_frame(mk(8'h3C, 0, 0, 1, 1, 0), 10, 4, -1);
        check("clamp_pre_valid", data_valid, 0);
        final_edge();
        RX_IN = 1'b1;
        check("clamp_valid", data_valid, 1);
        check("clamp_data", P_DATA, 8'h3C);
        data_ready = 1'b1;
        final_edge();
        data_ready = 1'b0;
        Prescale = 6'd8;
        idle_cycles(3);

        // T5: ready held low, second frame overruns
        drive_frame(mk(8'h11, 0, 0, 1, 1, 0), 10, 8, -1);
        final_edge();
        RX_IN = 1'b1;
        check("t5_first_valid", data_valid, 1);
        idle_cycles(3);
        drive_frame(mk(8'h22, 0, 0, 1, 1, 0), 10, 8, -1);
        final_edge();
        RX_IN = 1'b1;
        check("t5_overrun", overrun, 1);
        check("t5_kept_data", P_DATA, 8'h11);
        check("t5_still_valid", data_valid, 1);
        final_edge();
        check("t5_overrun_pulse", overrun, 0);
        idle_cycles(3);
        // accept on the completion edge: new word replaces old, no overrun
        drive_frame(mk(8'h22, 0, 0, 1, 1, 0), 10, 8, -1);
        data_ready = 1'b1;
        final_edge();
        RX_IN = 1'b1;
        check("t5b_data", P_DATA, 8'h22);
        check("t5b_valid", data_valid, 1);
        check("t5b_overrun", overrun, 0);
        final_edge();
        check("t5b_accept", data_valid, 0);
        data_ready = 1'b0;
        idle_cycles(3);

        // T6: reset in the middle of the data bits
        begin
            logic [15:0] b;
            b = mk(8'h5A, 0, 0, 1, 1, 0);
            for (int i = 0; i < 4; i++) begin
                RX_IN = b[i];
                repeat (8) @(posedge clk);
                #1;
            end
        end
        check("t6_pre_busy", busy, 1);
        rst = 1'b0;
        #1;
        check("t6_rst_busy", busy, 0);
        check("t6_rst_data", P_DATA, 8'h00);
        check("t6_rst_valid", data_valid, 0);
        RX_IN = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("t6_rst_par_err", par_err, 0);
        check("t6_rst_stp_err", stp_err, 0);
        rst = 1'b1;
        idle_cycles(4);
        check("t6_idle_busy", busy, 0);
        // PAR_EN raised mid-frame must not add a parity bit to this frame
        PAR_EN = 1'b0;
        drive_frame(mk(8'h5A, 0, 0, 1, 1, 0), 10, 8, 3);
        final_edge();
        RX_IN = 1'b1;
        check("t6_valid", data_valid, 1);
        check("t6_data", P_DATA, 8'h5A);
        check("t6_par_err", par_err, 0);
        check("t6_busy", busy, 0);
        PAR_EN = 1'b0;
        idle_cycles(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
